// File: rtl/stage_mem_if.sv
// Bundle of the EX->MEM, MEM<->data-memory and MEM->WB signals.
// slave: the MEM stage side; master: the surrounding pipeline/memory side.
interface stage_mem_if;
    // EX -> MEM
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_inst;
    logic [31:0] ex_newpc;
    logic [31:0] ex_aluoutput;
    logic [31:0] ex_regdatab;
    logic        ex_cond;
    logic        ex_memread;
    logic        ex_memwrite;
    // MEM <-> data memory
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    // MEM -> WB
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_inst;
    logic [31:0] wb_newpc;
    logic [31:0] wb_aluoutput;
    logic [31:0] wb_lmd;
    logic        wb_cond;
    logic        wb_err;

    modport slave (
        input  ex_valid, ex_inst, ex_newpc, ex_aluoutput, ex_regdatab,
        input  ex_cond, ex_memread, ex_memwrite,
        output ex_ready,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        output wb_valid, wb_inst, wb_newpc, wb_aluoutput, wb_lmd,
        output wb_cond, wb_err,
        input  wb_ready
    );

    modport master (
        output ex_valid, ex_inst, ex_newpc, ex_aluoutput, ex_regdatab,
        output ex_cond, ex_memread, ex_memwrite,
        input  ex_ready,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        input  wb_valid, wb_inst, wb_newpc, wb_aluoutput, wb_lmd,
        input  wb_cond, wb_err,
        output wb_ready
    );
endinterface

// File: rtl/stage_mem.sv
// MEM pipeline stage: accepts one EX result, runs at most one data-memory
// access with a timeout, and hands the result to WB over valid/ready.
// Ports: clk, rst (sync, active-high); bus = stage_mem_if.slave carrying
// the ex_* input handshake, dm_* memory request/ack and wb_* output handshake.
module stage_mem #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    stage_mem_if.slave  bus
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    // Abort fires in the ACCESS cycle whose miss would make the count
    // reach TIMEOUT_CYCLES, so dm_req is high exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] inst_q, inst_d;
    logic [31:0] newpc_q, newpc_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rdb_q, rdb_d;
    logic        cond_q, cond_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_inst_q, wb_inst_d;
    logic [31:0] wb_newpc_q, wb_newpc_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_lmd_q, wb_lmd_d;
    logic        wb_cond_q, wb_cond_d;
    logic        wb_err_q, wb_err_d;

    logic        ex_ready;
    logic        accept;
    logic        mem_op;
    logic        fault;
    logic        finish;

    assign ex_ready = (state_q == IDLE) && (!wb_valid_q || bus.wb_ready);
    assign accept   = bus.ex_valid && ex_ready;
    assign mem_op   = bus.ex_memread || bus.ex_memwrite;
    assign fault    = (bus.ex_memread && bus.ex_memwrite)
                   || (mem_op && (bus.ex_aluoutput[1:0] != 2'b00));
    // Ack has priority over the timeout when both land in one cycle.
    assign finish   = bus.dm_ack || (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inst_d     = inst_q;
        newpc_d    = newpc_q;
        alu_d      = alu_q;
        rdb_d      = rdb_q;
        cond_d     = cond_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wb_valid_d = wb_valid_q;
        wb_inst_d  = wb_inst_q;
        wb_newpc_d = wb_newpc_q;
        wb_alu_d   = wb_alu_q;
        wb_lmd_d   = wb_lmd_q;
        wb_cond_d  = wb_cond_q;
        wb_err_d   = wb_err_q;

        if (wb_valid_q && bus.wb_ready) begin
            wb_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    inst_d  = bus.ex_inst;
                    newpc_d = bus.ex_newpc;
                    alu_d   = bus.ex_aluoutput;
                    rdb_d   = bus.ex_regdatab;
                    cond_d  = bus.ex_cond;
                    rd_d    = bus.ex_memread;
                    wr_d    = bus.ex_memwrite;
                    if (!mem_op || fault) begin
                        // Completes without touching memory.
                        wb_valid_d = 1'b1;
                        wb_inst_d  = bus.ex_inst;
                        wb_newpc_d = bus.ex_newpc;
                        wb_alu_d   = bus.ex_aluoutput;
                        wb_cond_d  = bus.ex_cond;
                        wb_lmd_d   = '0;
                        wb_err_d   = fault;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (finish) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_inst_d  = inst_q;
                    wb_newpc_d = newpc_q;
                    wb_alu_d   = alu_q;
                    wb_cond_d  = cond_q;
                    wb_lmd_d   = (bus.dm_ack && rd_q) ? bus.dm_rdata : '0;
                    wb_err_d   = !bus.dm_ack;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inst_q     <= '0;
            newpc_q    <= '0;
            alu_q      <= '0;
            rdb_q      <= '0;
            cond_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_inst_q  <= '0;
            wb_newpc_q <= '0;
            wb_alu_q   <= '0;
            wb_lmd_q   <= '0;
            wb_cond_q  <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inst_q     <= inst_d;
            newpc_q    <= newpc_d;
            alu_q      <= alu_d;
            rdb_q      <= rdb_d;
            cond_q     <= cond_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wb_valid_q <= wb_valid_d;
            wb_inst_q  <= wb_inst_d;
            wb_newpc_q <= wb_newpc_d;
            wb_alu_q   <= wb_alu_d;
            wb_lmd_q   <= wb_lmd_d;
            wb_cond_q  <= wb_cond_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // The memory request is driven straight from the holding registers,
    // which cannot change while in ACCESS, so it stays stable until ack.
    assign bus.ex_ready     = ex_ready;
    assign bus.dm_req       = (state_q == ACCESS);
    assign bus.dm_we        = (state_q == ACCESS) && wr_q;
    assign bus.dm_addr      = alu_q;
    assign bus.dm_wdata     = wr_q ? rdb_q : '0;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_inst      = wb_inst_q;
    assign bus.wb_newpc     = wb_newpc_q;
    assign bus.wb_aluoutput = wb_alu_q;
    assign bus.wb_lmd       = wb_lmd_q;
    assign bus.wb_cond      = wb_cond_q;
    assign bus.wb_err       = wb_err_q;

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: random EX traffic, a latency-programmable
// memory responder and a WB monitor, plus directed latency/reset cases.
module tb_stage_mem;

    localparam int TO = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] newpc;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic        cond;
        logic        err;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } dm_t;

    logic clk;
    logic rst;
    stage_mem_if bus ();

    stage_mem #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    logic bp_rand = 1'b0;
    logic bp_val = 1'b1;
    logic resp_off = 1'b0;

    wb_t sb_q[$];
    dm_t dm_q[$];
    int  lat_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] resp_mem [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a memory op either completes after lat cycles or,
    // if lat exceeds the timeout, faults; loads see all prior stores.
    task automatic issue(input logic [31:0] inst, input logic [31:0] newpc,
                         input logic [31:0] alu, input logic [31:0] rdb,
                         input logic cond, input logic rd, input logic wr,
                         input int lat);
        int  guard;
        wb_t e;
        dm_t d;
        guard = 0;
        @(negedge clk);
        bus.ex_valid     = 1'b1;
        bus.ex_inst      = inst;
        bus.ex_newpc     = newpc;
        bus.ex_aluoutput = alu;
        bus.ex_regdatab  = rdb;
        bus.ex_cond      = cond;
        bus.ex_memread   = rd;
        bus.ex_memwrite  = wr;
        #1;
        while (!bus.ex_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!bus.ex_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_accept: ex_ready=0 for 200 cycles, expected 1");
            bus.ex_valid = 1'b0;
            return;
        end
        e.inst  = inst;
        e.newpc = newpc;
        e.alu   = alu;
        e.cond  = cond;
        e.lmd   = '0;
        e.err   = 1'b0;
        if (rd && wr) begin
            e.err = 1'b1;
        end else if ((rd || wr) && alu[1:0] != 2'b00) begin
            e.err = 1'b1;
        end else if (rd || wr) begin
            d.addr  = alu;
            d.we    = wr;
            d.wdata = wr ? rdb : 32'h0;
            dm_q.push_back(d);
            lat_q.push_back(lat);
            if (lat > TO) begin
                e.err = 1'b1;
            end else if (rd) begin
                e.lmd = ref_mem.exists(alu) ? ref_mem[alu] : init_word(alu);
            end else begin
                ref_mem[alu] = rdb;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        last_acc = cyc;
        bus.ex_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n, output logic rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            #2;
            n++;
            if (bus.wb_valid) break;
            if (bus.ex_ready) rdy_seen = 1'b1;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (bp_rand) bus.wb_ready = ($urandom % 4) != 0;
        else         bus.wb_ready = bp_val;
    end

    // Memory responder: acks in the lat-th request cycle and checks the
    // request is stable; after a timeout it fires one stray ack.
    initial begin
        int   k;
        int   lat;
        dm_t  d;
        logic act;
        act = 1'b0;
        k   = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (resp_off) begin
                act = 1'b0;
                continue;
            end
            bus.dm_ack = 1'b0;
            if (act && !bus.dm_req) begin
                chk("dm_req_cycles", 32'(k), 32'((lat > TO) ? TO : lat));
                if (lat > TO) begin
                    bus.dm_ack   = 1'b1;
                    bus.dm_rdata = $urandom;
                end
                act = 1'b0;
            end else if (!act && bus.dm_req) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dm_unexpected: dm_req=1 addr=%h, expected no request",
                             bus.dm_addr);
                end else begin
                    d   = dm_q.pop_front();
                    lat = lat_q.pop_front();
                    act = 1'b1;
                    k   = 0;
                end
            end
            if (act && bus.dm_req) begin
                k++;
                chk("dm_addr", bus.dm_addr, d.addr);
                chk1("dm_we", bus.dm_we, d.we);
                chk("dm_wdata", bus.dm_wdata, d.wdata);
                if (k == lat) begin
                    bus.dm_ack = 1'b1;
                    if (d.we) begin
                        resp_mem[d.addr] = d.wdata;
                        bus.dm_rdata = $urandom;
                    end else begin
                        bus.dm_rdata = resp_mem.exists(d.addr)
                                     ? resp_mem[d.addr] : init_word(d.addr);
                    end
                end
            end
        end
    end

    // WB monitor: pops on handshake, checks hold under backpressure.
    initial begin
        wb_t  h;
        wb_t  e;
        logic stall;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk1("hold_valid", bus.wb_valid, 1'b1);
                chk("hold_inst", bus.wb_inst, h.inst);
                chk("hold_alu", bus.wb_aluoutput, h.alu);
                chk("hold_lmd", bus.wb_lmd, h.lmd);
                chk1("hold_err", bus.wb_err, h.err);
            end
            if (bus.wb_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: wb_valid=1 inst=%h, expected none",
                             bus.wb_inst);
                end else if (bus.wb_ready) begin
                    e = sb_q.pop_front();
                    chk("wb_inst", bus.wb_inst, e.inst);
                    chk("wb_newpc", bus.wb_newpc, e.newpc);
                    chk("wb_alu", bus.wb_aluoutput, e.alu);
                    chk("wb_lmd", bus.wb_lmd, e.lmd);
                    chk1("wb_cond", bus.wb_cond, e.cond);
                    chk1("wb_err", bus.wb_err, e.err);
                end
                if (!bus.wb_ready) chk1("ex_ready_stall", bus.ex_ready, 1'b0);
            end
            stall   = bus.wb_valid && !bus.wb_ready;
            h.inst  = bus.wb_inst;
            h.alu   = bus.wb_aluoutput;
            h.lmd   = bus.wb_lmd;
            h.err   = bus.wb_err;
        end
    end

    task automatic chk_zero(input string tag);
        chk1({tag, "_dm_req"}, bus.dm_req, 1'b0);
        chk1({tag, "_dm_we"}, bus.dm_we, 1'b0);
        chk({tag, "_dm_addr"}, bus.dm_addr, 32'h0);
        chk({tag, "_dm_wdata"}, bus.dm_wdata, 32'h0);
        chk1({tag, "_wb_valid"}, bus.wb_valid, 1'b0);
        chk1({tag, "_wb_err"}, bus.wb_err, 1'b0);
        chk1({tag, "_wb_cond"}, bus.wb_cond, 1'b0);
        chk({tag, "_wb_inst"}, bus.wb_inst, 32'h0);
        chk({tag, "_wb_newpc"}, bus.wb_newpc, 32'h0);
        chk({tag, "_wb_alu"}, bus.wb_aluoutput, 32'h0);
        chk({tag, "_wb_lmd"}, bus.wb_lmd, 32'h0);
    endtask

    initial begin
        int          n;
        int          prev;
        int          kind;
        logic        rs;
        logic [31:0] a;
        rst = 1'b1;
        bus.ex_valid     = 1'b0;
        bus.ex_inst      = '0;
        bus.ex_newpc     = '0;
        bus.ex_aluoutput = '0;
        bus.ex_regdatab  = '0;
        bus.ex_cond      = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_memwrite  = 1'b0;
        bus.dm_ack       = 1'b0;
        bus.dm_rdata     = '0;
        bus.wb_ready     = 1'b1;
        ref_mem[32'h100]  = 32'hDEADBEEF;
        resp_mem[32'h100] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk1("ready_after_reset", bus.ex_ready, 1'b1);

        issue(32'h00221820, 32'h4, 32'h2A, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        wait_wb(n, rs);
        chk("alu_latency", 32'(n), 32'd1);

        issue(32'h8C010100, 32'h8, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 3);
        wait_wb(n, rs);
        chk("load3_latency", 32'(n), 32'd4);
        chk1("load3_ex_ready_low", rs, 1'b0);

        issue(32'hAC020204, 32'hC, 32'h204, 32'h12345678, 1'b1, 1'b0, 1'b1, 2);
        wait_wb(n, rs);
        chk("store_latency", 32'(n), 32'd3);

        issue(32'h8C030204, 32'h10, 32'h204, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        wait_wb(n, rs);
        chk("load1_latency", 32'(n), 32'd2);

        issue(32'h8C040102, 32'h14, 32'h102, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        wait_wb(n, rs);
        chk("misaligned_latency", 32'(n), 32'd1);

        issue(32'h8C050108, 32'h18, 32'h108, 32'h0, 1'b0, 1'b1, 1'b0, 9);
        wait_wb(n, rs);
        chk("timeout_latency", 32'(n), 32'(TO + 1));

        issue(32'h8C06010C, 32'h1C, 32'h10C, 32'h0, 1'b1, 1'b1, 1'b0, TO);
        wait_wb(n, rs);
        chk("ack_at_timeout_latency", 32'(n), 32'(TO + 1));

        issue(32'hFC070110, 32'h20, 32'h110, 32'h55, 1'b0, 1'b1, 1'b1, 1);
        wait_wb(n, rs);
        chk("both_rw_latency", 32'(n), 32'd1);

        issue(32'h00000001, 32'h24, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            prev = last_acc;
            issue(32'h10 + 32'(i), 32'h28, 32'(i), 32'h0, 1'b1, 1'b0, 1'b0, 1);
            chk("b2b_throughput", 32'(last_acc - prev), 32'd1);
        end

        bp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            kind = $urandom % 8;
            a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            if (kind <= 2) begin
                issue($urandom, $urandom, $urandom, $urandom, 1'($urandom),
                      1'b0, 1'b0, 1);
            end else if (kind <= 4) begin
                issue($urandom, $urandom, a, $urandom, 1'($urandom),
                      1'b1, 1'b0, $urandom_range(1, 6));
            end else if (kind == 5) begin
                issue($urandom, $urandom, a, $urandom, 1'($urandom),
                      1'b0, 1'b1, $urandom_range(1, 6));
            end else if (kind == 6) begin
                issue($urandom, $urandom, a | 32'($urandom_range(1, 3)),
                      $urandom, 1'($urandom), 1'($urandom), 1'b1, 1);
            end else begin
                issue($urandom, $urandom, $urandom, $urandom, 1'($urandom),
                      1'b1, 1'b1, 1);
            end
        end

        bp_rand = 1'b0;
        bp_val  = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || bus.wb_valid) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

        bp_val = 1'b0;
        @(negedge clk);
        issue(32'h00430820, 32'h40, 32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 1);
        wait_wb(n, rs);
        chk("bp_latency", 32'(n), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            chk1("bp_ex_ready", bus.ex_ready, 1'b0);
            chk1("bp_wb_valid", bus.wb_valid, 1'b1);
        end
        bp_val = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk1("bp_released", bus.wb_valid, 1'b0);

        resp_off = 1'b1;
        issue(32'h8C080100, 32'h44, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 50);
        @(negedge clk);
        #2;
        chk1("rst_in_access", bus.dm_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk_zero("rst_mid");
        sb_q.delete();
        dm_q.delete();
        lat_q.delete();
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk1("rst_release_ready", bus.ex_ready, 1'b1);
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'hBADC0DE5;
        @(negedge clk);
        #2;
        bus.dm_ack = 1'b0;
        chk1("late_ack_no_valid", bus.wb_valid, 1'b0);
        chk1("late_ack_no_req", bus.dm_req, 1'b0);
        @(negedge clk);
        #2;
        chk1("late_ack_idle", bus.ex_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
